// File: rtl/img_mem_server_if.sv
// Accelerator bus and host port bundle for the image memory server.
interface img_mem_server_if;
  logic [15:0] addr;
  logic [31:0] dataW;
  logic        en;
  logic        we;
  logic [31:0] dataR;
  logic        start;
  logic        finish;
  logic        host_valid;
  logic        host_we;
  logic [15:0] host_addr;
  logic [31:0] host_wdata;
  logic        host_ready;
  logic        host_rvalid;
  logic [31:0] host_rdata;

  modport master (
    output addr, dataW, en, we, finish,
    output host_valid, host_we, host_addr, host_wdata,
    input  dataR, start, host_ready, host_rvalid, host_rdata
  );

  modport slave (
    input  addr, dataW, en, we, finish,
    input  host_valid, host_we, host_addr, host_wdata,
    output dataR, start, host_ready, host_rvalid, host_rdata
  );
endinterface

// File: rtl/img_mem_server.sv
// Image memory server: source/result word store, accelerator
// responder with 1-cycle read latency, and host load/dump port.
module img_mem_server #(
  parameter int IMG_W       = 352,
  parameter int IMG_H       = 288,
  parameter bit PROTECT_SRC = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  img_mem_server_if.slave   bus,
  input  logic              go,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       cycles
);
  localparam int RES_BASE = IMG_W * IMG_H / 4;
  localparam int DEPTH    = 2 * RES_BASE;
  localparam int AW       = $clog2(DEPTH);
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);
  localparam logic [16:0] RES_L   = 17'(RES_BASE);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [31:0] mem [DEPTH];

  logic          acc_en;
  logic          acc_ok;
  logic          acc_prot;
  logic          host_acc;
  logic          host_ok;
  logic          mem_we;
  logic [AW-1:0] mem_a;
  logic [31:0]   mem_wd;

  assign bus.host_ready = !busy && !go;

  assign acc_en   = (state == RUN) && bus.en;
  assign acc_ok   = {1'b0, bus.addr} < DEPTH_L;
  assign acc_prot = PROTECT_SRC && bus.we &&
                    ({1'b0, bus.addr} < RES_L);
  assign host_acc = bus.host_valid && bus.host_ready;
  assign host_ok  = {1'b0, bus.host_addr} < DEPTH_L;

  // One shared port: the accelerator owns it in RUN, the host otherwise.
  always_comb begin
    mem_we = 1'b0;
    mem_a  = bus.host_addr[AW-1:0];
    mem_wd = bus.host_wdata;
    if (acc_en) begin
      mem_a  = bus.addr[AW-1:0];
      mem_wd = bus.dataW;
      mem_we = bus.we && acc_ok && !acc_prot;
    end else if (host_acc) begin
      mem_we = bus.host_we && host_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_a] <= mem_wd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.dataR       <= '0;
      bus.host_rdata  <= '0;
      bus.host_rvalid <= 1'b0;
      err             <= 1'b0;
    end else begin
      bus.host_rvalid <= host_acc && !bus.host_we;
      if (acc_en && !bus.we)
        bus.dataR <= acc_ok ? mem[mem_a] : '0;
      if (host_acc && !bus.host_we)
        bus.host_rdata <= host_ok ? mem[mem_a] : '0;
      if ((acc_en && (!acc_ok || acc_prot)) ||
          (host_acc && !host_ok))
        err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bus.start <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cycles    <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (go) begin
            state     <= RUN;
            bus.start <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            cycles    <= '0;
          end
        end
        RUN: begin
          if (cycles != '1) cycles <= cycles + 32'd1;
          if (bus.finish) begin
            state     <= DONE;
            bus.start <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_img_mem_server.sv
// Randomized bench for img_mem_server against a word-array
// reference model of the memory, run counter and error flag.
module tb_img_mem_server;
  localparam int IMG_W    = 352;
  localparam int IMG_H    = 288;
  localparam int RES_BASE = IMG_W * IMG_H / 4;
  localparam int DEPTH    = 2 * RES_BASE;

  logic        clk = 1'b0;
  logic        reset;
  logic        go;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] cycles;

  img_mem_server_if bus();

  img_mem_server #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H),
    .PROTECT_SRC(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .go(go),
    .busy(busy),
    .done(done),
    .err(err),
    .cycles(cycles)
  );

  always #5 clk = ~clk;

  int          n_chk;
  int          n_fail;
  bit [31:0]   model [int];
  bit          exp_err;
  logic [31:0] exp_dataR;
  int          runc;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    go             = 1'b0;
    bus.en         = 1'b0;
    bus.we         = 1'b0;
    bus.addr       = '0;
    bus.dataW      = '0;
    bus.finish     = 1'b0;
    bus.host_valid = 1'b0;
    bus.host_we    = 1'b0;
    bus.host_addr  = '0;
    bus.host_wdata = '0;
  endtask

  function automatic logic [31:0] mval(int a);
    if (a >= DEPTH) return 32'h0;
    return model[a];
  endfunction

  function automatic logic [15:0] pick();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return 16'($urandom_range(DEPTH, 65535));
    if (r < 5)  return 16'($urandom_range(0, 15));
    return 16'(RES_BASE + int'($urandom_range(0, 15)));
  endfunction

  task automatic host_wr(logic [15:0] a, logic [31:0] d);
    bus.host_valid = 1'b1;
    bus.host_we    = 1'b1;
    bus.host_addr  = a;
    bus.host_wdata = d;
    tick();
    bus.host_valid = 1'b0;
    if (int'(a) < DEPTH) model[int'(a)] = d;
    else exp_err = 1'b1;
  endtask

  task automatic host_rd(logic [15:0] a, string tag);
    bus.host_valid = 1'b1;
    bus.host_we    = 1'b0;
    bus.host_addr  = a;
    tick();
    bus.host_valid = 1'b0;
    if (int'(a) >= DEPTH) exp_err = 1'b1;
    check({tag, "_rvalid"}, 32'(bus.host_rvalid), 32'd1);
    check({tag, "_rdata"}, bus.host_rdata, mval(int'(a)));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
  endtask

  task automatic acc_op(bit en, bit we, logic [15:0] a,
                        logic [31:0] d, string tag);
    bus.en    = en;
    bus.we    = we;
    bus.addr  = a;
    bus.dataW = d;
    tick();
    bus.en = 1'b0;
    runc++;
    if (en && we) begin
      if (int'(a) >= DEPTH || int'(a) < RES_BASE) exp_err = 1'b1;
      else model[int'(a)] = d;
    end else if (en) begin
      exp_dataR = mval(int'(a));
      if (int'(a) >= DEPTH) exp_err = 1'b1;
    end
    check({tag, "_dataR"}, bus.dataR, exp_dataR);
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_cycles"}, cycles, 32'(runc));
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    exp_err   = 1'b0;
    exp_dataR = '0;
    runc      = 0;
    quiet();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_start", 32'(bus.start), 32'd0);
    check("rst_dataR", bus.dataR, 32'd0);
    check("rst_hrdata", bus.host_rdata, 32'd0);
    check("rst_hrvalid", 32'(bus.host_rvalid), 32'd0);
    check("rst_cycles", cycles, 32'd0);
    check("rst_hready", 32'(bus.host_ready), 32'd1);

    host_wr(16'd5, 32'h04030201);
    host_rd(16'd5, "h_rd5");
    tick();
    check("h_rvalid_pulse", 32'(bus.host_rvalid), 32'd0);

    for (int i = 0; i < 16; i++) begin
      if (i != 5) host_wr(16'(i), $urandom);
      host_wr(16'(RES_BASE + i), $urandom);
    end
    for (int i = 0; i < 8; i++)
      host_rd(16'($urandom_range(0, 15)), "h_rnd");

    go             = 1'b1;
    bus.host_valid = 1'b1;
    bus.host_we    = 1'b1;
    bus.host_addr  = 16'd5;
    bus.host_wdata = 32'hBAD0BAD0;
    #1;
    check("hready_go", 32'(bus.host_ready), 32'd0);
    tick();
    quiet();
    runc = 0;
    check("go_busy", 32'(busy), 32'd1);
    check("go_start", 32'(bus.start), 32'd1);
    check("go_done", 32'(done), 32'd0);
    check("go_cycles", cycles, 32'd0);

    acc_op(1, 0, 16'd5, '0, "a_rd5");
    bus.host_valid = 1'b1;
    #1;
    check("hready_run", 32'(bus.host_ready), 32'd0);
    bus.host_valid = 1'b0;
    acc_op(1, 1, 16'(RES_BASE), 32'hDEADBEEF, "a_wr_res");
    acc_op(1, 0, 16'(RES_BASE), '0, "a_rd_res");
    acc_op(1, 1, 16'd3, 32'h12345678, "a_wr_prot");
    acc_op(1, 0, 16'hFFFF, '0, "a_rd_oob");
    acc_op(1, 0, 16'd3, '0, "a_rd3");

    for (int i = 0; i < 60; i++)
      acc_op(($urandom_range(0, 4) != 0), 1'($urandom), pick(),
             $urandom, "a_rnd");
    while (runc < 99) acc_op(0, 0, '0, '0, "a_idle");

    bus.finish = 1'b1;
    tick();
    bus.finish = 1'b0;
    check("fin_start", 32'(bus.start), 32'd0);
    check("fin_busy", 32'(busy), 32'd0);
    check("fin_done", 32'(done), 32'd1);
    check("fin_cycles", cycles, 32'd100);

    bus.en    = 1'b1;
    bus.we    = 1'b1;
    bus.addr  = 16'(RES_BASE + 1);
    bus.dataW = 32'hCAFEF00D;
    bus.finish = 1'b1;
    tick();
    quiet();
    check("done_dataR_hold", bus.dataR, exp_dataR);
    check("done_sticky", 32'(done), 32'd1);
    check("done_cycles_hold", cycles, 32'd100);
    host_rd(16'(RES_BASE + 1), "h_res1");
    for (int i = 0; i < 8; i++)
      host_rd(16'(RES_BASE + int'($urandom_range(0, 15))), "h_dump");

    go = 1'b1;
    tick();
    go = 1'b0;
    check("go2_done", 32'(done), 32'd0);
    check("go2_cycles", cycles, 32'd0);
    repeat (4) tick();
    check("run2_cycles", cycles, 32'd4);
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    exp_err = 1'b0;
    check("rr_start", 32'(bus.start), 32'd0);
    check("rr_busy", 32'(busy), 32'd0);
    check("rr_err", 32'(err), 32'd0);
    check("rr_cycles", cycles, 32'd0);
    check("rr_hready", 32'(bus.host_ready), 32'd1);
    host_rd(16'd5, "h_rd5_after");
    host_rd(16'hFFFF, "h_oob");
    host_wr(16'hFFF0, 32'h1);
    tick();
    check("h_oob_err", 32'(err), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
